// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder between the UART RX FIFO and the clock/sensor control logic.
// Define UART_CMD_ECHO_EN to echo every latched character into the TX FIFO.

module uart_cmd_decoder #(
  parameter int NUM_MODES      = 5,
  parameter int BTN_PULSE      = 4,
  parameter int PREFIX_TIMEOUT = 1000000
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iRx_Empty,
  output logic                 oRx_Rd,
  input  logic [7:0]           iRx_Data,
  input  logic                 iTx_Full,
  output logic                 oTx_Wr,
  output logic [7:0]           oTx_Data,
  output logic                 oSet,
  output logic                 oFnd_Mode,
  output logic [NUM_MODES-1:0] oMode,
  output logic [3:0]           oBtn,
  output logic                 oTime_En,
  output logic                 oErr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LATCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int CNT_W  = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam int HOLD_W = (BTN_PULSE > 1) ? $clog2(BTN_PULSE) : 1;

  localparam logic [CNT_W-1:0]     PREFIX_LOAD = CNT_W'(PREFIX_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]    HOLD_LOAD   = HOLD_W'(BTN_PULSE - 1);
  localparam logic [NUM_MODES-1:0] MODE_BASE   = NUM_MODES'(1);

  logic [1:0]        state;
  logic              prefixFlag;
  logic [CNT_W-1:0]  prefixCnt;
  logic [HOLD_W-1:0] holdCnt;
  logic              timeoutNow;
  logic              digitOk;
  logic [3:0]        digitVal;

  function automatic logic [NUM_MODES-1:0] modeHot(input logic [3:0] idx);
    return MODE_BASE << idx;
  endfunction

  // A pending '#' that has run out of time owns the IDLE cycle, so no fetch happens then.
  always_comb begin
    timeoutNow = (state == IDLE) && prefixFlag && (prefixCnt == '0);
    digitVal   = iRx_Data[3:0];
    digitOk    = (iRx_Data[7:4] == 4'h3) && (digitVal <= 4'd9) &&
                 (int'(digitVal) < NUM_MODES);
  end

  assign oRx_Rd = (state == IDLE) && !iRx_Empty && !timeoutNow;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state      <= IDLE;
      prefixFlag <= 1'b0;
      prefixCnt  <= '0;
      holdCnt    <= '0;
      oSet       <= 1'b0;
      oFnd_Mode  <= 1'b0;
      oMode      <= MODE_BASE;
      oBtn       <= 4'b0000;
      oTime_En   <= 1'b0;
      oErr       <= 1'b0;
    end else begin
      oTime_En <= 1'b0;
      oErr     <= 1'b0;
      if (prefixFlag && (prefixCnt != '0)) begin
        prefixCnt <= prefixCnt - CNT_W'(1);
      end

      case (state)
        IDLE: begin
          // Button pulses stay up through the first IDLE cycle to make BTN_PULSE cycles total.
          oBtn <= 4'b0000;
          if (timeoutNow) begin
            prefixFlag <= 1'b0;
            oErr       <= 1'b1;
          end else if (!iRx_Empty) begin
            state <= LATCH;
          end
        end

        LATCH: begin
          state <= IDLE;
          if (prefixFlag) begin
            prefixFlag <= 1'b0;
            if (digitOk) begin
              oMode <= modeHot(digitVal);
            end else begin
              oErr <= 1'b1;
            end
          end else begin
            case (iRx_Data)
              "C": oMode <= modeHot(4'd0);
              "W": oMode <= modeHot(4'd1);
              "T": oMode <= modeHot(4'd2);
              "U": oMode <= modeHot(4'd3);
              "D": oMode <= modeHot(4'd4);
              "S": oSet      <= !oSet;
              "M": oFnd_Mode <= !oFnd_Mode;
              "X": oTime_En  <= 1'b1;
              "u", "d", "l", "r": begin
                case (iRx_Data)
                  "u":     oBtn <= 4'b1000;
                  "d":     oBtn <= 4'b0100;
                  "l":     oBtn <= 4'b0010;
                  default: oBtn <= 4'b0001;
                endcase
                if (BTN_PULSE > 1) begin
                  state   <= HOLD;
                  holdCnt <= HOLD_LOAD;
                end
              end
              "#": begin
                prefixFlag <= 1'b1;
                prefixCnt  <= PREFIX_LOAD;
              end
              8'h0D, 8'h0A: ;
              default: oErr <= 1'b1;
            endcase
          end
        end

        HOLD: begin
          if (holdCnt <= HOLD_W'(1)) begin
            state <= IDLE;
          end else begin
            holdCnt <= holdCnt - HOLD_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_CMD_ECHO_EN
  // Echo is best effort: a full TX FIFO drops the character instead of stalling decode.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oTx_Wr   <= 1'b0;
      oTx_Data <= 8'h00;
    end else begin
      oTx_Wr <= 1'b0;
      if ((state == LATCH) && !iTx_Full) begin
        oTx_Wr   <= 1'b1;
        oTx_Data <= iRx_Data;
      end
    end
  end
`else
  logic unusedTxFull;
  assign unusedTxFull = iTx_Full;
  assign oTx_Wr       = 1'b0;
  assign oTx_Data     = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: FIFO emulation plus a cycle-scheduled command model.
// Build with UART_CMD_ECHO_EN defined to also exercise the echo path.

module tb_uart_cmd_decoder;

  localparam int NM = 8;
  localparam int BP = 4;
  localparam int PT = 16;

  logic          iClk;
  logic          iRst;
  logic          iRx_Empty;
  logic          oRx_Rd;
  logic [7:0]    iRx_Data;
  logic          iTx_Full;
  logic          oTx_Wr;
  logic [7:0]    oTx_Data;
  logic          oSet;
  logic          oFnd_Mode;
  logic [NM-1:0] oMode;
  logic [3:0]    oBtn;
  logic          oTime_En;
  logic          oErr;

  uart_cmd_decoder #(.NUM_MODES(NM), .BTN_PULSE(BP), .PREFIX_TIMEOUT(PT)) dut (
    .iClk(iClk), .iRst(iRst), .iRx_Empty(iRx_Empty), .oRx_Rd(oRx_Rd),
    .iRx_Data(iRx_Data), .iTx_Full(iTx_Full), .oTx_Wr(oTx_Wr), .oTx_Data(oTx_Data),
    .oSet(oSet), .oFnd_Mode(oFnd_Mode), .oMode(oMode), .oBtn(oBtn),
    .oTime_En(oTime_En), .oErr(oErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] fifoQ[$];
  logic [7:0] staged[$];

  // Model: effects are scheduled by absolute cycle number rather than by state.
  int         modeIdx;
  bit         mSet, mFnd, prefixOn, pendValid, popNext, txFullAtEdge, blockFetch;
  logic [3:0] btnMask;
  logic [7:0] pendCh, mTxData;
  int         btnStart, btnEnd, timeCycle, errCycle, txCycle;
  int         prefixDeadline, pendCycle, nextFetch;

  bit          expRd, expTime, expErr, expTxWr;
  logic [NM-1:0] expMode;
  logic [3:0]  expBtn;
  logic [7:0]  expTxData;

  task automatic modelReset();
    modeIdx = 0; mSet = 0; mFnd = 0; prefixOn = 0; pendValid = 0; popNext = 0;
    btnMask = 4'b0; btnStart = -1000; btnEnd = -1000; timeCycle = -1000;
    errCycle = -1000; txCycle = -1000; mTxData = 8'h00; nextFetch = 0;
  endtask

  function automatic bit isBtn(input logic [7:0] ch);
    return (ch == "u") || (ch == "d") || (ch == "l") || (ch == "r");
  endfunction

  task automatic applyChar(input logic [7:0] ch);
`ifdef UART_CMD_ECHO_EN
    if (!txFullAtEdge) begin
      txCycle = cyc;
      mTxData = ch;
    end
`endif
    if (prefixOn) begin
      prefixOn = 0;
      if (ch >= "0" && ch <= "9" && int'(ch - 8'h30) < NM) modeIdx = int'(ch - 8'h30);
      else errCycle = cyc;
    end else begin
      case (ch)
        "C": modeIdx = 0;
        "W": modeIdx = 1;
        "T": modeIdx = 2;
        "U": modeIdx = 3;
        "D": modeIdx = 4;
        "S": mSet = !mSet;
        "M": mFnd = !mFnd;
        "X": timeCycle = cyc;
        "u", "d", "l", "r": begin
          btnMask  = (ch == "u") ? 4'b1000 : (ch == "d") ? 4'b0100 :
                     (ch == "l") ? 4'b0010 : 4'b0001;
          btnStart = cyc;
          btnEnd   = cyc + BP;
        end
        "#": begin
          prefixOn       = 1;
          prefixDeadline = cyc - 1 + PT;
        end
        8'h0D, 8'h0A: ;
        default: errCycle = cyc;
      endcase
    end
  endtask

  // Advances one clock, refreshes the FIFO inputs after the edge, then computes expectations at the negedge.
  task automatic step();
    @(posedge iClk);
    txFullAtEdge = iTx_Full;
    #1;
    if (popNext) begin
      iRx_Data = fifoQ.pop_front();
      popNext  = 0;
    end
    while (staged.size() > 0) fifoQ.push_back(staged.pop_front());
    iRx_Empty = (fifoQ.size() == 0);
    cyc++;
    @(negedge iClk);
    if (pendValid && pendCycle == cyc) begin
      applyChar(pendCh);
      pendValid = 0;
    end
    blockFetch = 0;
    if (prefixOn && !pendValid && cyc == prefixDeadline) begin
      prefixOn   = 0;
      errCycle   = cyc + 1;
      blockFetch = 1;
    end
    expRd = (cyc >= nextFetch) && (fifoQ.size() > 0) && !blockFetch;
    if (expRd) begin
      pendCh    = fifoQ[0];
      pendValid = 1;
      pendCycle = cyc + 2;
      nextFetch = (isBtn(fifoQ[0]) && !prefixOn) ? cyc + 1 + BP : cyc + 2;
    end
    popNext   = oRx_Rd && (fifoQ.size() > 0);
    expMode   = '0;
    expMode[modeIdx] = 1'b1;
    expBtn    = (cyc >= btnStart && cyc < btnEnd) ? btnMask : 4'b0000;
    expTime   = (timeCycle == cyc);
    expErr    = (errCycle == cyc);
    expTxWr   = (txCycle == cyc);
    expTxData = mTxData;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iRx_Empty = 1'b1; iRx_Data = 8'h00; iTx_Full = 1'b0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    total++; if (oMode !== 8'b00000001) begin bad++; $display("[TB] FAIL rst_mode got=%b exp=%b", oMode, 8'b00000001); end
    total++; if (oSet !== 1'b0 || oFnd_Mode !== 1'b0) begin bad++; $display("[TB] FAIL rst_levels got=%b%b exp=00", oSet, oFnd_Mode); end
    total++; if (oBtn !== 4'b0000) begin bad++; $display("[TB] FAIL rst_btn got=%b exp=0000", oBtn); end
    total++; if (oTime_En !== 1'b0 || oErr !== 1'b0) begin bad++; $display("[TB] FAIL rst_pulses got=%b%b exp=00", oTime_En, oErr); end
    total++; if (oTx_Wr !== 1'b0 || oTx_Data !== 8'h00) begin bad++; $display("[TB] FAIL rst_tx got=%b/%h exp=0/00", oTx_Wr, oTx_Data); end
    total++; if (oRx_Rd !== 1'b0) begin bad++; $display("[TB] FAIL rst_rd got=%b exp=0", oRx_Rd); end
    iRst = 1'b0;
    modelReset();
    cyc = 0;
  endtask

  task automatic test_basic();
    staged.push_back("W"); staged.push_back("S"); staged.push_back("M");
    for (int i = 0; i < 9; i++) begin
      step();
      total++; if (oRx_Rd !== expRd) begin bad++; $display("[TB] FAIL basic_rd cyc=%0d got=%b exp=%b", cyc, oRx_Rd, expRd); end
      total++; if (oMode !== expMode) begin bad++; $display("[TB] FAIL basic_mode cyc=%0d got=%b exp=%b", cyc, oMode, expMode); end
      total++; if (oSet !== mSet || oFnd_Mode !== mFnd) begin bad++; $display("[TB] FAIL basic_levels cyc=%0d got=%b%b exp=%b%b", cyc, oSet, oFnd_Mode, mSet, mFnd); end
      total++; if (oErr !== 1'b0) begin bad++; $display("[TB] FAIL basic_err cyc=%0d got=%b exp=0", cyc, oErr); end
    end
    total++; if (oMode !== 8'b00000010 || oSet !== 1'b1 || oFnd_Mode !== 1'b1) begin bad++; $display("[TB] FAIL basic_final got=%b %b%b exp=00000010 11", oMode, oSet, oFnd_Mode); end
  endtask

  task automatic test_button();
    int highCnt = 0;
    staged.push_back("u"); staged.push_back("C");
    for (int i = 0; i < 10; i++) begin
      step();
      if (oBtn === 4'b1000) highCnt++;
      total++; if (oBtn !== expBtn) begin bad++; $display("[TB] FAIL btn_level cyc=%0d got=%b exp=%b", cyc, oBtn, expBtn); end
      total++; if (oRx_Rd !== expRd) begin bad++; $display("[TB] FAIL btn_rd cyc=%0d got=%b exp=%b", cyc, oRx_Rd, expRd); end
      if (i >= 1 && i <= 4) begin
        total++; if (oRx_Rd !== 1'b0) begin bad++; $display("[TB] FAIL btn_noread cyc=%0d got=%b exp=0", cyc, oRx_Rd); end
      end
    end
    total++; if (highCnt != BP) begin bad++; $display("[TB] FAIL btn_width got=%0d exp=%0d", highCnt, BP); end
    total++; if (oMode !== 8'b00000001) begin bad++; $display("[TB] FAIL btn_next_cmd got=%b exp=00000001", oMode); end
  endtask

  task automatic test_prefix();
    int errCnt = 0;
    staged.push_back("#"); staged.push_back("6");
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if (oMode !== expMode) begin bad++; $display("[TB] FAIL pfx_mode cyc=%0d got=%b exp=%b", cyc, oMode, expMode); end
      total++; if (oErr !== expErr) begin bad++; $display("[TB] FAIL pfx_err cyc=%0d got=%b exp=%b", cyc, oErr, expErr); end
    end
    total++; if (oMode !== 8'b01000000) begin bad++; $display("[TB] FAIL pfx_digit6 got=%b exp=01000000", oMode); end
    staged.push_back("#"); staged.push_back("9"); staged.push_back("#"); staged.push_back("S");
    for (int i = 0; i < 10; i++) begin
      step();
      if (oErr === 1'b1) errCnt++;
      total++; if (oMode !== expMode) begin bad++; $display("[TB] FAIL pfx_hold_mode cyc=%0d got=%b exp=%b", cyc, oMode, expMode); end
      total++; if (oErr !== expErr) begin bad++; $display("[TB] FAIL pfx_bad_err cyc=%0d got=%b exp=%b", cyc, oErr, expErr); end
      total++; if (oSet !== mSet) begin bad++; $display("[TB] FAIL pfx_set cyc=%0d got=%b exp=%b", cyc, oSet, mSet); end
    end
    total++; if (errCnt != 2) begin bad++; $display("[TB] FAIL pfx_errcount got=%0d exp=2", errCnt); end
    total++; if (oMode !== 8'b01000000 || oSet !== 1'b1) begin bad++; $display("[TB] FAIL pfx_final got=%b %b exp=01000000 1", oMode, oSet); end
  endtask

  task automatic test_timeout();
    int errCnt = 0;
    int errAt  = -1;
    staged.push_back("#");
    for (int i = 0; i < 22; i++) begin
      step();
      if (oErr === 1'b1) begin errCnt++; errAt = i; end
      total++; if (oErr !== expErr) begin bad++; $display("[TB] FAIL tmo_err cyc=%0d got=%b exp=%b", cyc, oErr, expErr); end
      total++; if (oRx_Rd !== expRd) begin bad++; $display("[TB] FAIL tmo_rd cyc=%0d got=%b exp=%b", cyc, oRx_Rd, expRd); end
    end
    total++; if (errCnt != 1 || errAt != PT + 2) begin bad++; $display("[TB] FAIL tmo_when got=%0d@%0d exp=1@%0d", errCnt, errAt, PT + 2); end
    staged.push_back("T");
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (oMode !== expMode) begin bad++; $display("[TB] FAIL tmo_next_mode cyc=%0d got=%b exp=%b", cyc, oMode, expMode); end
    end
    total++; if (oMode !== 8'b00000100) begin bad++; $display("[TB] FAIL tmo_final got=%b exp=00000100", oMode); end
  endtask

  task automatic test_misc();
    int errCnt  = 0;
    int timeCnt = 0;
    staged.push_back("Z"); staged.push_back(8'h0D); staged.push_back(8'h0A); staged.push_back("X");
    for (int i = 0; i < 12; i++) begin
      step();
      if (oErr === 1'b1) errCnt++;
      if (oTime_En === 1'b1) timeCnt++;
      total++; if (oErr !== expErr) begin bad++; $display("[TB] FAIL misc_err cyc=%0d got=%b exp=%b", cyc, oErr, expErr); end
      total++; if (oTime_En !== expTime) begin bad++; $display("[TB] FAIL misc_time cyc=%0d got=%b exp=%b", cyc, oTime_En, expTime); end
      total++; if (oMode !== expMode || oSet !== mSet || oFnd_Mode !== mFnd) begin bad++; $display("[TB] FAIL misc_held cyc=%0d got=%b %b%b exp=%b %b%b", cyc, oMode, oSet, oFnd_Mode, expMode, mSet, mFnd); end
    end
    total++; if (errCnt != 1 || timeCnt != 1) begin bad++; $display("[TB] FAIL misc_counts got=%0d/%0d exp=1/1", errCnt, timeCnt); end
  endtask

  task automatic test_echo();
    int wrCnt = 0;
    bit saw57 = 0;
    iTx_Full = 1'b0;
    staged.push_back("W");
    for (int i = 0; i < 4; i++) begin
      step();
      if (oTx_Wr === 1'b1) begin wrCnt++; if (oTx_Data === 8'h57) saw57 = 1; end
      total++; if (oTx_Wr !== expTxWr || oTx_Data !== expTxData) begin bad++; $display("[TB] FAIL echo_wr cyc=%0d got=%b/%h exp=%b/%h", cyc, oTx_Wr, oTx_Data, expTxWr, expTxData); end
    end
    iTx_Full = 1'b1;
    staged.push_back("S");
    for (int i = 0; i < 4; i++) begin
      step();
      if (oTx_Wr === 1'b1) wrCnt++;
      total++; if (oTx_Wr !== expTxWr || oTx_Data !== expTxData) begin bad++; $display("[TB] FAIL echo_full cyc=%0d got=%b/%h exp=%b/%h", cyc, oTx_Wr, oTx_Data, expTxWr, expTxData); end
      total++; if (oSet !== mSet) begin bad++; $display("[TB] FAIL echo_decode cyc=%0d got=%b exp=%b", cyc, oSet, mSet); end
    end
    iTx_Full = 1'b0;
`ifdef UART_CMD_ECHO_EN
    total++; if (wrCnt != 1 || !saw57) begin bad++; $display("[TB] FAIL echo_count got=%0d/%b exp=1/1", wrCnt, saw57); end
`else
    total++; if (wrCnt != 0) begin bad++; $display("[TB] FAIL echo_tied got=%0d exp=0", wrCnt); end
`endif
  endtask

  task automatic test_reset_mid();
    int errCnt = 0;
    staged.push_back("u");
    repeat (4) step();
    total++; if (oBtn !== 4'b1000) begin bad++; $display("[TB] FAIL rstmid_pre_btn got=%b exp=1000", oBtn); end
    iRst = 1'b1;
    #1;
    total++; if (oBtn !== 4'b0000 || oMode !== 8'b00000001) begin bad++; $display("[TB] FAIL rstmid_hold got=%b %b exp=0000 00000001", oBtn, oMode); end
    fifoQ.delete(); staged.delete(); iRx_Empty = 1'b1; modelReset();
    @(posedge iClk); @(negedge iClk); cyc++;
    iRst = 1'b0;
    staged.push_back("#");
    repeat (4) step();
    iRst = 1'b1;
    #1;
    total++; if (oMode !== 8'b00000001 || oErr !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_prefix got=%b %b exp=00000001 0", oMode, oErr); end
    fifoQ.delete(); staged.delete(); iRx_Empty = 1'b1; modelReset();
    @(posedge iClk); @(negedge iClk); cyc++;
    iRst = 1'b0;
    staged.push_back("5");
    for (int i = 0; i < 5; i++) begin
      step();
      if (oErr === 1'b1) errCnt++;
      total++; if (oErr !== expErr || oMode !== expMode) begin bad++; $display("[TB] FAIL rstmid_digit cyc=%0d got=%b %b exp=%b %b", cyc, oErr, oMode, expErr, expMode); end
    end
    total++; if (errCnt != 1) begin bad++; $display("[TB] FAIL rstmid_errcount got=%0d exp=1", errCnt); end
  endtask

  task automatic test_random();
    logic [7:0] pool [0:23] = '{"C", "W", "T", "U", "D", "S", "M", "X", "u", "d", "l", "r",
                                "#", "#", "0", "3", "5", "7", "8", "9", 8'h0D, 8'h0A, "Z", "a"};
    int pct;
    for (int i = 0; i < 600; i++) begin
      pct = ((i / 60) % 3 == 2) ? 2 : 45;
      if ((staged.size() + fifoQ.size() < 3) && ($urandom_range(0, 99) < pct)) begin
        if ($urandom_range(0, 9) == 0) staged.push_back(8'($urandom_range(0, 255)));
        else staged.push_back(pool[$urandom_range(0, 23)]);
      end
      step();
      iTx_Full = ($urandom_range(0, 3) == 0);
      total++; if (oRx_Rd !== expRd) begin bad++; $display("[TB] FAIL rnd_rd cyc=%0d got=%b exp=%b", cyc, oRx_Rd, expRd); end
      total++; if (oMode !== expMode) begin bad++; $display("[TB] FAIL rnd_mode cyc=%0d got=%b exp=%b", cyc, oMode, expMode); end
      total++; if (oSet !== mSet || oFnd_Mode !== mFnd) begin bad++; $display("[TB] FAIL rnd_levels cyc=%0d got=%b%b exp=%b%b", cyc, oSet, oFnd_Mode, mSet, mFnd); end
      total++; if (oBtn !== expBtn) begin bad++; $display("[TB] FAIL rnd_btn cyc=%0d got=%b exp=%b", cyc, oBtn, expBtn); end
      total++; if (oTime_En !== expTime || oErr !== expErr) begin bad++; $display("[TB] FAIL rnd_pulses cyc=%0d got=%b%b exp=%b%b", cyc, oTime_En, oErr, expTime, expErr); end
      total++; if (oTx_Wr !== expTxWr || oTx_Data !== expTxData) begin bad++; $display("[TB] FAIL rnd_tx cyc=%0d got=%b/%h exp=%b/%h", cyc, oTx_Wr, oTx_Data, expTxWr, expTxData); end
    end
    iTx_Full = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_button();
    test_prefix();
    test_timeout();
    test_misc();
    test_echo();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Parametrised ASCII command decoder between the UART RX FIFO and the clock/sensor control logic.
- Pops characters from the RX FIFO using a read-strobe handshake and decodes single-letter commands into level controls (set, FND mode, display mode) and pulse controls (buttons, time display, error).
- Generalises mode selection to NUM_MODES one-hot modes, including a two-character "#n" direct-select command with timeout.
- Button pulses have programmable width.

Parameters:
NUM_MODES, 5, number of display modes; one-hot width of oMode; legal range 5..10
BTN_PULSE, 4, cycles each oBtn bit stays high per button command; minimum 1
PREFIX_TIMEOUT, 1000000, cycles allowed between '#' and its digit (10 ms at 100 MHz)

Ports:
iClk  in  1  system clock
iRst  in  1  asynchronous, active-high reset
iRx_Empty  in  1  RX FIFO empty flag
oRx_Rd  out  1  RX FIFO read strobe, one cycle per character
iRx_Data  in  8  RX FIFO data, valid the cycle after oRx_Rd
iTx_Full  in  1  TX FIFO full flag (echo path)
oTx_Wr  out  1  TX FIFO write strobe (echo path)
oTx_Data  out  8  echoed character
oSet  out  1  set-mode level, toggled by 'S'
oFnd_Mode  out  1  FND display-mode level, toggled by 'M'
oMode  out  NUM_MODES  one-hot display mode
oBtn  out  4  {U,D,L,R} button pulses
oTime_En  out  1  one-cycle pulse on 'X'
oErr  out  1  one-cycle pulse on an unrecognised char, a bad digit, or a prefix timeout

Behaviour:
- Reset values: oSet=0, oFnd_Mode=0, oMode=1 (bit0), oBtn=0, oTime_En=0, oErr=0, oTx_Wr=0, oTx_Data=0, prefix flag cleared, FSM in IDLE. Reset mid-operation aborts any pulse or prefix immediately.
- FSM states: IDLE, LATCH, HOLD.
- IDLE:
  - oRx_Rd = (state==IDLE) && !iRx_Empty (combinational).
  - If asserted, go to LATCH.
  - Exception: prefix timeout expiring (see below) blocks the fetch that cycle.
- LATCH:
  - Decode iRx_Data. All outputs update on the next edge (registered, 1-cycle latency).
  - A button command goes to HOLD; anything else returns to IDLE.
  - Maximum throughput: 1 character per 2 cycles.
- Normal decode (prefix flag clear):
  - 'C','W','T','U','D' select oMode one-hot bit 0,1,2,3,4 respectively.
  - 'S' toggles oSet; 'M' toggles oFnd_Mode.
  - 'X' pulses oTime_En for one cycle.
  - 'u','d','l','r' assert oBtn[3],[2],[1],[0] for exactly BTN_PULSE cycles, starting the cycle after LATCH.
  - '#' sets the prefix flag and loads the timeout counter with PREFIX_TIMEOUT-1.
  - CR (0x0D) and LF (0x0A) are ignored silently.
  - Any other byte pulses oErr; all other state is held.
- HOLD:
  - Counts BTN_PULSE-1 cycles, then returns to IDLE and clears oBtn.
  - No FIFO reads during HOLD.
  - BTN_PULSE=1 returns to IDLE directly from LATCH.
- Prefix:
  - While the flag is set, the counter decrements every cycle in every state.
  - The next decoded char is consumed by the prefix, never decoded normally.
  - If it is '0'..'9' with value < NUM_MODES, oMode becomes one-hot of that value.
  - Otherwise oErr pulses and oMode is held.
  - The flag clears in either case.
- Timeout: in IDLE with the flag set and the counter at 0, clear the flag and pulse oErr. No fetch that cycle, even if the FIFO is non-empty.
- Simultaneous events: a digit latched in LATCH while the counter reaches 0 counts as a valid digit; the LATCH decode takes priority over the timeout.
- Mode bits at index ≥ 5 are reachable only via "#n".
- oMode is always exactly one-hot.

Optional Feature:
- Macro: UART_CMD_ECHO_EN.
- Defined: each LATCH cycle with !iTx_Full produces a one-cycle oTx_Wr on the next edge, with oTx_Data = the latched char. Includes ignored and error characters.
- Defined, iTx_Full high: the echo is dropped, never stalled; the decoder is unaffected.
- Undefined: oTx_Wr and oTx_Data are tied to 0, iTx_Full is unused, and the ports remain present.

Test Plan:
- Reset, then FIFO supplies 'W','S','M' -> oMode=00010, oSet=1, oFnd_Mode=1; each output updates 2 cycles after its oRx_Rd; oErr never pulses.
- 'u' with BTN_PULSE=4 while a second char waits in the FIFO -> oBtn=1000 for exactly 4 cycles; the next oRx_Rd occurs only after HOLD ends.
- NUM_MODES=8: "#6" -> oMode=01000000. "#9" -> oErr pulse, oMode unchanged. "#" then 'S' -> oErr pulse, oSet unchanged.
- PREFIX_TIMEOUT=16: '#' followed by an empty FIFO -> oErr pulses 16 cycles after LATCH. A subsequent 'T' decodes normally -> oMode=00100.
- Byte 'Z' -> oErr 1-cycle pulse. CR/LF -> no outputs change. 'X' -> oTime_En high for exactly 1 cycle.
- Async iRst asserted mid-HOLD and mid-prefix -> oBtn=0 immediately, oMode=00001, and after release the next '5' is flagged as error rather than treated as a mode digit. With UART_CMD_ECHO_EN defined: 'W' -> oTx_Wr with 0x57; iTx_Full=1 -> no oTx_Wr, decoding proceeds.
